// File: rtl/l1_l2_arbiter.sv
// Round-robin arbiter between the instruction and data L1 caches for the single
// shared L2 port. One requester is granted at a time; its address, operation and
// write line are latched and held until the L2 completes, then the completion is
// forwarded to the granted side only.
module l1_l2_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  // icache side
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  // dcache side
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  // shared L2 port
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StGrantI = 2'd1,
    StGrantD = 2'd2
  } state_e;

  state_e              state_q, state_d;
  // 0: icache served last, 1: dcache served last
  logic                last_q, last_d;
  logic                op_write_q, op_write_d;
  logic                l2_read_q, l2_read_d;
  logic                l2_write_q, l2_write_d;
  logic [ADDR_W-1:0]   l2_address_q, l2_address_d;
  logic [LINE_W-1:0]   l2_wdata_q, l2_wdata_d;

  logic                i_req;
  logic                d_req;
  logic                grant_i;
  logic                grant_d;

  // Arbitration, grant latching and completion handling.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    op_write_d   = op_write_q;
    l2_read_d    = l2_read_q;
    l2_write_d   = l2_write_q;
    l2_address_d = l2_address_q;
    l2_wdata_d   = l2_wdata_q;

    i_req   = i_read;
    d_req   = d_read | d_write;
    grant_i = 1'b0;
    grant_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        // On contention the side not served last wins.
        grant_i = i_req & (~d_req | last_q);
        grant_d = d_req & (~i_req | ~last_q);
        if (grant_i) begin
          state_d      = StGrantI;
          last_d       = 1'b0;
          op_write_d   = 1'b0;
          l2_read_d    = 1'b1;
          l2_write_d   = 1'b0;
          l2_address_d = i_address;
        end else if (grant_d) begin
          state_d      = StGrantD;
          last_d       = 1'b1;
          // Read and write together is treated as a write-back.
          op_write_d   = d_write;
          l2_read_d    = ~d_write;
          l2_write_d   = d_write;
          l2_address_d = d_address;
          l2_wdata_d   = d_wdata;
        end
      end
      StGrantI, StGrantD: begin
        l2_read_d  = ~op_write_q;
        l2_write_d = op_write_q;
        if (l2_resp) begin
          state_d    = StIdle;
          l2_read_d  = 1'b0;
          l2_write_d = 1'b0;
        end
      end
      default: begin
        state_d    = StIdle;
        l2_read_d  = 1'b0;
        l2_write_d = 1'b0;
      end
    endcase
  end

  // State and latched request registers; reset drops L2 requests immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      last_q       <= 1'b1;
      op_write_q   <= 1'b0;
      l2_read_q    <= 1'b0;
      l2_write_q   <= 1'b0;
      l2_address_q <= '0;
      l2_wdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      op_write_q   <= op_write_d;
      l2_read_q    <= l2_read_d;
      l2_write_q   <= l2_write_d;
      l2_address_q <= l2_address_d;
      l2_wdata_q   <= l2_wdata_d;
    end
  end

  assign l2_read    = l2_read_q;
  assign l2_write   = l2_write_q;
  assign l2_address = l2_address_q;
  assign l2_wdata   = l2_wdata_q;

  // Read data is shared; only the resp pulses qualify it.
  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;

  // Completion goes to the granted side only; l2_resp in idle is dropped.
  assign i_resp = l2_resp & (state_q == StGrantI);
  assign d_resp = l2_resp & (state_q == StGrantD);

endmodule
